// File: rtl/pc_if.sv
// pc_if: fetch-redirect bus between the pipeline control and the program counter.
interface pc_if #(parameter int PC_W = 10);
  logic            stall_i;
  logic            redirect_valid_i;
  logic [PC_W-1:0] redirect_target_i;
  logic [PC_W-1:0] pc_o;
  logic            pc_valid_o;
  logic            flush_o;
  logic            fault_o;
  modport master (output stall_i, redirect_valid_i, redirect_target_i,
                  input  pc_o, pc_valid_o, flush_o, fault_o);
  modport slave  (input  stall_i, redirect_valid_i, redirect_target_i,
                  output pc_o, pc_valid_o, flush_o, fault_o);
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter FSM with stall, redirect/flush and wrap; define PC_TRAP_EN
// to trap out-of-range redirects to TRAP_PC with a sticky fault, otherwise targets wrap modulo MEM_WORDS.
module pc_unit #(
  parameter int PC_W      = 10,
  parameter int MEM_WORDS = 1024,
  parameter int RESET_PC  = 0,
  parameter int TRAP_PC   = 0
) (
  input logic clk,
  input logic reset,
  pc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STALL, FLUSH} state_t;
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, tgt, pc_inc;
  logic            valid_q, valid_d, flush_q, flush_d, fault_q, fault_d, redir;
  always_comb begin
    redir  = bus.redirect_valid_i && state_q != IDLE;
    pc_inc = pc_q == PC_W'(MEM_WORDS - 1) ? '0 : pc_q + 1'b1;
`ifdef PC_TRAP_EN
    tgt     = 32'(bus.redirect_target_i) >= MEM_WORDS ? PC_W'(TRAP_PC) : bus.redirect_target_i;
    fault_d = fault_q | (redir && 32'(bus.redirect_target_i) >= MEM_WORDS);
`else
    tgt     = PC_W'(32'(bus.redirect_target_i) % MEM_WORDS);
    fault_d = 1'b0;
`endif
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = 1'b1;
    flush_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = RUN;
      pc_d    = PC_W'(RESET_PC);
      valid_d = 1'b0;
    end else if (redir) begin
      state_d = FLUSH;
      pc_d    = tgt;
      valid_d = 1'b0;
      flush_d = 1'b1;
    end else if (bus.stall_i) begin
      state_d = STALL;
    end else begin
      state_d = RUN;
      // advance only past a PC that was actually presented as valid
      pc_d    = state_q == RUN && valid_q ? pc_inc : pc_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(RESET_PC);
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
    end
  end
  assign bus.pc_o       = pc_q;
  assign bus.pc_valid_o = valid_q;
  assign bus.flush_o    = flush_q;
  assign bus.fault_o    = fault_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit (default 1024-word and 512-word instances).
module tb_pc_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  pc_if #(.PC_W(10)) a();
  pc_if #(.PC_W(10)) b();
  pc_unit u0 (.clk(clk), .reset(reset), .bus(a));
  pc_unit #(.MEM_WORDS(512), .TRAP_PC(3)) u1 (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv_a(input logic s, input logic rv, input int t);
    a.stall_i = s;
    a.redirect_valid_i = rv;
    a.redirect_target_i = 10'(t);
  endtask
  task automatic chk_a(input string tag, input int pc, input int v, input int f);
    chk({tag, ".pc"}, int'(a.pc_o), pc);
    chk({tag, ".valid"}, int'(a.pc_valid_o), v);
    chk({tag, ".flush"}, int'(a.flush_o), f);
  endtask
  initial begin
    reset = 1'b0;
    drv_a(0, 0, 0);
    b.stall_i = 0; b.redirect_valid_i = 0; b.redirect_target_i = '0;
    #1 reset = 1'b1;
    #1 chk_a("rst", 0, 0, 0);
    chk("rst.fault", int'(a.fault_o), 0);
    step(); step();
    reset = 1'b0;
    step(); chk_a("edge1", 0, 0, 0);
    step(); chk_a("edge2", 0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      step(); chk_a($sformatf("inc%0d", i), i, 1, 0);
    end
    drv_a(0, 1, 200); step(); chk_a("redir200", 200, 0, 1);
    drv_a(0, 0, 999); step(); chk_a("post200", 200, 1, 0);
    step(); chk_a("inc201", 201, 1, 0);
    drv_a(0, 1, 7); step(); chk_a("redir7", 7, 0, 1);
    drv_a(0, 0, 999); step(); chk_a("at7", 7, 1, 0);
    drv_a(1, 0, 999); step(); chk_a("stall1", 7, 1, 0);
    drv_a(1, 1, 40); step(); chk_a("stall_redir", 40, 0, 1);
    drv_a(1, 0, 999); step(); chk_a("stall3", 40, 1, 0);
    step(); chk_a("stall4", 40, 1, 0);
    drv_a(0, 0, 999); step(); chk_a("unstall", 40, 1, 0);
    step(); chk_a("resume41", 41, 1, 0);
    drv_a(0, 1, 10); step(); chk_a("b2b10", 10, 0, 1);
    drv_a(0, 1, 20); step(); chk_a("b2b20", 20, 0, 1);
    drv_a(0, 0, 0); step(); chk_a("b2b_run", 20, 1, 0);
    step(); chk_a("b2b_inc", 21, 1, 0);
    drv_a(0, 1, 1022); step(); chk_a("redir1022", 1022, 0, 1);
    drv_a(0, 0, 0); step(); chk_a("at1022", 1022, 1, 0);
    step(); chk_a("at1023", 1023, 1, 0);
    step(); chk_a("wrap0", 0, 1, 0);
    step(); chk_a("wrap1", 1, 1, 0);
    reset = 1'b1;
    drv_a(0, 1, 300);
    step();
    reset = 1'b0;
    step(); chk_a("idle_ignore", 0, 0, 0);
    drv_a(0, 0, 0); step(); chk_a("idle_after", 0, 1, 0);
    step(); chk_a("idle_inc", 1, 1, 0);
    drv_a(1, 0, 0); step(); chk_a("pre_async", 1, 1, 0);
    #2 reset = 1'b1;
    #1 chk_a("async_stall", 0, 0, 0);
    drv_a(0, 0, 0);
    step();
    reset = 1'b0;
    step(); step();
    chk("b.run_valid", int'(b.pc_valid_o), 1);
    b.redirect_valid_i = 1; b.redirect_target_i = 10'd600;
    step();
`ifdef PC_TRAP_EN
    chk("b.oor.pc", int'(b.pc_o), 3);
    chk("b.oor.fault", int'(b.fault_o), 1);
`else
    chk("b.oor.pc", int'(b.pc_o), 88);
    chk("b.oor.fault", int'(b.fault_o), 0);
`endif
    chk("b.oor.flush", int'(b.flush_o), 1);
    chk("b.oor.valid", int'(b.pc_valid_o), 0);
    b.redirect_valid_i = 0; b.redirect_target_i = 10'd900;
    step();
`ifdef PC_TRAP_EN
    chk("b.hold.pc", int'(b.pc_o), 3);
    chk("b.hold.fault", int'(b.fault_o), 1);
`else
    chk("b.hold.pc", int'(b.pc_o), 88);
    chk("b.hold.fault", int'(b.fault_o), 0);
`endif
    chk("b.hold.valid", int'(b.pc_valid_o), 1);
    b.redirect_valid_i = 1; b.redirect_target_i = 10'd100;
    step();
    chk("b.r100.pc", int'(b.pc_o), 100);
    chk("b.r100.flush", int'(b.flush_o), 1);
`ifdef PC_TRAP_EN
    chk("b.r100.fault", int'(b.fault_o), 1);
`else
    chk("b.r100.fault", int'(b.fault_o), 0);
`endif
    #2 reset = 1'b1;
    #1 chk("b.async.pc", int'(b.pc_o), 0);
    chk("b.async.flush", int'(b.flush_o), 0);
    chk("b.async.fault", int'(b.fault_o), 0);
    chk("b.async.valid", int'(b.pc_valid_o), 0);
    b.redirect_valid_i = 0;
    step();
    reset = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL provide parameter PC_W, default 10, the program-counter width as a word index into instruction memory.
REQ-002 The block SHALL provide parameter MEM_WORDS, default 1024, the number of valid instruction words; legal range 2..2^PC_W.
REQ-003 The block SHALL provide parameter RESET_PC, default 0, the first word index fetched after reset.
REQ-004 The block SHALL provide parameter TRAP_PC, default 0, the word index jumped to on an out-of-range redirect when PC_TRAP_EN is defined.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port stall_i, input, 1 bit, a downstream request to hold the current PC.
REQ-008 The block SHALL have port redirect_valid_i, input, 1 bit, a branch/jump taken request.
REQ-009 The block SHALL have port redirect_target_i, input, PC_W bits, the branch/jump target word index.
REQ-010 The block SHALL have port pc_o, output, PC_W bits, the word index presented to fetch, driven from a register.
REQ-011 The block SHALL have port pc_valid_o, output, 1 bit, meaning pc_o is a real fetch request.
REQ-012 The block SHALL have port flush_o, output, 1 bit, a one-cycle pulse telling fetch/decode to discard the instruction in flight.
REQ-013 The block SHALL have port fault_o, output, 1 bit, a sticky out-of-range-redirect flag.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN, STALL and FLUSH, encoded in a registered state variable.
REQ-015 IDLE: pc_o SHALL hold RESET_PC, with pc_valid_o=0, and the FSM SHALL go unconditionally to RUN on the next edge.
REQ-016 RUN with no stall and no redirect: pc_o SHALL advance by 1 per cycle, with pc_valid_o=1.
REQ-017 Increment wrap: pc_o = MEM_WORDS-1 SHALL advance to 0, not to MEM_WORDS.
REQ-018 stall_i=1 in RUN or STALL with no redirect: pc_o SHALL hold, pc_valid_o SHALL stay 1, and the FSM SHALL be in STALL; stall_i=0 SHALL return the FSM to RUN and resume incrementing on the following edge.
REQ-019 Redirect priority: redirect_valid_i=1 SHALL override stall_i in every state except IDLE.
REQ-020 A redirect sampled in cycle N SHALL produce, in cycle N+1, pc_o=redirect_target_i, flush_o=1, pc_valid_o=0, state FLUSH.
REQ-021 From FLUSH with no new redirect, the FSM SHALL go to RUN (or to STALL if stall_i=1), with pc_valid_o=1 and pc_o still equal to the target; incrementing SHALL resume the cycle after that.
REQ-022 A redirect during FLUSH SHALL load the new target and stay in FLUSH for one more cycle, with flush_o=1 again.
REQ-023 flush_o SHALL be high only in FLUSH cycles and never for two cycles from a single redirect.
REQ-024 A redirect in IDLE SHALL be ignored.
REQ-025 redirect_target_i SHALL be sampled only when redirect_valid_i=1.

Reset
REQ-026 reset=1 SHALL immediately force state=IDLE, pc_o=RESET_PC, pc_valid_o=0, flush_o=0 and fault_o=0, independent of clk.
REQ-027 Reset asserted mid-FLUSH or mid-STALL SHALL discard the pending target and stall.
REQ-028 After reset deasserts, the first pc_valid_o=1 SHALL occur on the second rising edge.

Configuration
REQ-029 With macro PC_TRAP_EN defined, a redirect target >= MEM_WORDS SHALL load TRAP_PC instead of the target, still enter FLUSH, and set fault_o=1, which stays set until reset.
REQ-030 Without PC_TRAP_EN, fault_o SHALL be tied to 0 and an out-of-range target SHALL be loaded modulo MEM_WORDS.

Verification
REQ-031 Release reset with stall_i=0 and redirect_valid_i=0 -> pc_valid_o rises on the 2nd edge; pc_o reads 0,1,2,3 on consecutive cycles.
REQ-032 Run to pc_o=1023 with MEM_WORDS=1024 -> next pc_o=0 and pc_valid_o stays 1.
REQ-033 At pc_o=5, pulse redirect_valid_i with redirect_target_i=200 -> next cycle pc_o=200, flush_o=1, pc_valid_o=0; then pc_o=200 with valid; then pc_o=201.
REQ-034 Hold stall_i=1 for 3 cycles at pc_o=7 with a redirect to 40 on cycle 2 -> pc_o stays 7, then goes to 40 via FLUSH, then resumes incrementing only once stall_i=0.
REQ-035 Back-to-back redirects to 10 then 20 -> two FLUSH cycles with flush_o=1 each; RUN resumes at pc_o=20.
REQ-036 With MEM_WORDS=512: redirect to 600 -> with PC_TRAP_EN, pc_o=TRAP_PC and fault_o=1 held; without it, pc_o=88 and fault_o=0; a reset pulse mid-FLUSH returns pc_o to 0 asynchronously.
